// File: rtl/int_iq1_slot8.sv
// -----------------------------------------------------------------------------
// int_iq1_slot8 : eight-entry integer issue queue with age-ordered selection.
//
// Each entry holds a 32-bit payload, a 5-bit slot index, two 6-bit source tags
// and their ready bits. Broadcast tags wake matching sources. Every cycle the
// oldest entry (by enqueue order) with both sources ready is moved into a
// single-entry issue register whenever that register is empty or being
// consumed. Each move returns the entry's slot index to the free list one
// cycle later.
//
// Ports
//   Clk, Rest            clock, synchronous active-high reset
//   EnqValid/EnqSlot     enqueue strobe and slot index (bits [4:2] pick entry)
//   EnqSrc1/EnqSrc2      source tags of the enqueued op
//   EnqSrc1Rdy/Src2Rdy   source already ready at enqueue
//   EnqData              opaque payload
//   WakeValid/WakeTag    result-tag broadcast
//   Flush                drop every entry and the issue register
//   IssueReady           execute unit accepts the issue register
//   IssueValid/Data/Slot issue register
//   FreeWable/FreeDin    one-cycle slot return to the free list
//   Occupancy            number of valid entries (0..8)
//   SlotErr              sticky bad-enqueue flag
//
// Optional feature: define INT_IQ_SLOT_CHECK_EN to reject enqueues that hit an
// occupied entry or carry a misaligned slot index (EnqSlot[1:0] != 0), and to
// flag them on SlotErr. Without it SlotErr is tied low and such an enqueue
// simply overwrites the entry, which then becomes the youngest.
// -----------------------------------------------------------------------------
module int_iq1_slot8 (
  input  logic        Clk,
  input  logic        Rest,
  input  logic        EnqValid,
  input  logic [4:0]  EnqSlot,
  input  logic [5:0]  EnqSrc1,
  input  logic [5:0]  EnqSrc2,
  input  logic        EnqSrc1Rdy,
  input  logic        EnqSrc2Rdy,
  input  logic [31:0] EnqData,
  input  logic        WakeValid,
  input  logic [5:0]  WakeTag,
  input  logic        Flush,
  input  logic        IssueReady,
  output logic        IssueValid,
  output logic [31:0] IssueData,
  output logic [4:0]  IssueSlot,
  output logic        FreeWable,
  output logic [4:0]  FreeDin,
  output logic [3:0]  Occupancy,
  output logic        SlotErr
);

  logic [7:0]  entValid;
  logic [31:0] entData [8];
  logic [4:0]  entSlot [8];
  logic [5:0]  entTag1 [8];
  logic [5:0]  entTag2 [8];
  logic [7:0]  entRdy1;
  logic [7:0]  entRdy2;

  // Age matrix stored row-wise: olderMask[i][j] = 1 means entry j was
  // enqueued before entry i. Bits for invalid entries may be stale; they are
  // masked by eligibility and rewritten when that entry is enqueued again.
  logic [7:0]  olderMask [8];

  logic [2:0]  enqIdx;
  logic        enqAccept;
  logic        enqRdy1;
  logic        enqRdy2;
  logic [7:0]  eligible;
  logic [7:0]  selOneHot;
  logic [2:0]  selIdx;
  logic        doLoad;
  logic [7:0]  validNext;
  logic [3:0]  occNext;

  assign enqIdx = EnqSlot[4:2];

  // A source matching a same-cycle broadcast is captured as already ready.
  assign enqRdy1 = EnqSrc1Rdy || (WakeValid && (WakeTag == EnqSrc1));
  assign enqRdy2 = EnqSrc2Rdy || (WakeValid && (WakeTag == EnqSrc2));

`ifdef INT_IQ_SLOT_CHECK_EN
  logic enqBad;
  logic slotErrQ;

  assign enqBad    = EnqValid && (entValid[enqIdx] || (EnqSlot[1:0] != 2'b00));
  assign enqAccept = EnqValid && !enqBad;
  assign SlotErr   = slotErrQ;

  // Sticky until reset; a flushed enqueue never counts as an attempt.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      slotErrQ <= 1'b0;
    end else if (enqBad && !Flush) begin
      slotErrQ <= 1'b1;
    end
  end
`else
  assign enqAccept = EnqValid;
  assign SlotErr   = 1'b0;
`endif

  // Oldest-eligible pick: an eligible entry wins when no other eligible entry
  // is older than it. The age order is total over valid entries, so at most
  // one bit of selOneHot is set.
  always_comb begin
    eligible  = entValid & entRdy1 & entRdy2;
    selOneHot = '0;
    selIdx    = '0;
    for (int i = 0; i < 8; i++) begin
      selOneHot[i] = eligible[i] && ((eligible & olderMask[i]) == 8'd0);
    end
    for (int i = 0; i < 8; i++) begin
      if (selOneHot[i]) begin
        selIdx = 3'(i);
      end
    end
    doLoad = (!IssueValid || IssueReady) && (eligible != 8'd0);

    // An enqueue into the entry being issued this edge keeps the new op.
    validNext = entValid;
    if (doLoad) begin
      validNext[selIdx] = 1'b0;
    end
    if (enqAccept) begin
      validNext[enqIdx] = 1'b1;
    end

    occNext = '0;
    for (int i = 0; i < 8; i++) begin
      occNext = occNext + {3'b000, validNext[i]};
    end
  end

  // Entry storage, wakeup, age update and the issue/return registers.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      entValid   <= '0;
      entRdy1    <= '0;
      entRdy2    <= '0;
      for (int i = 0; i < 8; i++) begin
        olderMask[i] <= '0;
      end
      IssueValid <= 1'b0;
      IssueData  <= '0;
      IssueSlot  <= '0;
      FreeWable  <= 1'b0;
      FreeDin    <= '0;
      Occupancy  <= '0;
    end else if (Flush) begin
      // The free list re-initialises itself, so nothing is returned here.
      entValid   <= '0;
      IssueValid <= 1'b0;
      FreeWable  <= 1'b0;
      Occupancy  <= '0;
    end else begin
      entValid  <= validNext;
      Occupancy <= occNext;

      if (WakeValid) begin
        for (int i = 0; i < 8; i++) begin
          if (entValid[i] && (entTag1[i] == WakeTag)) begin
            entRdy1[i] <= 1'b1;
          end
          if (entValid[i] && (entTag2[i] == WakeTag)) begin
            entRdy2[i] <= 1'b1;
          end
        end
      end

      FreeWable <= doLoad;
      if (doLoad) begin
        IssueValid <= 1'b1;
        IssueData  <= entData[selIdx];
        IssueSlot  <= entSlot[selIdx];
        FreeDin    <= entSlot[selIdx];
      end else if (IssueReady) begin
        IssueValid <= 1'b0;
      end

      // New entry is younger than everything: all others become older than
      // it, and it is removed from every other row's older set.
      if (enqAccept) begin
        entData[enqIdx]   <= EnqData;
        entSlot[enqIdx]   <= EnqSlot;
        entTag1[enqIdx]   <= EnqSrc1;
        entTag2[enqIdx]   <= EnqSrc2;
        entRdy1[enqIdx]   <= enqRdy1;
        entRdy2[enqIdx]   <= enqRdy2;
        olderMask[enqIdx] <= ~(8'b0000_0001 << enqIdx);
        for (int k = 0; k < 8; k++) begin
          if (3'(k) != enqIdx) begin
            olderMask[k][enqIdx] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_int_iq1_slot8.sv
// -----------------------------------------------------------------------------
// tb_int_iq1_slot8 : self-checking bench for int_iq1_slot8.
//
// Directed scenarios check reset, single issue, issue order, age ordering,
// wakeup timing, issue hold, flush and the optional slot check (built with or
// without INT_IQ_SLOT_CHECK_EN). A randomized run compares the DUT every cycle
// against a queue-based model kept in enqueue order.
// -----------------------------------------------------------------------------
module tb_int_iq1_slot8;

`ifdef INT_IQ_SLOT_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic        Clk;
  logic        Rest;
  logic        EnqValid;
  logic [4:0]  EnqSlot;
  logic [5:0]  EnqSrc1;
  logic [5:0]  EnqSrc2;
  logic        EnqSrc1Rdy;
  logic        EnqSrc2Rdy;
  logic [31:0] EnqData;
  logic        WakeValid;
  logic [5:0]  WakeTag;
  logic        Flush;
  logic        IssueReady;
  logic        IssueValid;
  logic [31:0] IssueData;
  logic [4:0]  IssueSlot;
  logic        FreeWable;
  logic [4:0]  FreeDin;
  logic [3:0]  Occupancy;
  logic        SlotErr;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [4:0]  slot;
    logic [31:0] data;
    logic [5:0]  t1;
    logic [5:0]  t2;
    bit          r1;
    bit          r2;
  } ent_t;

  int_iq1_slot8 dut (
    .Clk        (Clk),
    .Rest       (Rest),
    .EnqValid   (EnqValid),
    .EnqSlot    (EnqSlot),
    .EnqSrc1    (EnqSrc1),
    .EnqSrc2    (EnqSrc2),
    .EnqSrc1Rdy (EnqSrc1Rdy),
    .EnqSrc2Rdy (EnqSrc2Rdy),
    .EnqData    (EnqData),
    .WakeValid  (WakeValid),
    .WakeTag    (WakeTag),
    .Flush      (Flush),
    .IssueReady (IssueReady),
    .IssueValid (IssueValid),
    .IssueData  (IssueData),
    .IssueSlot  (IssueSlot),
    .FreeWable  (FreeWable),
    .FreeDin    (FreeDin),
    .Occupancy  (Occupancy),
    .SlotErr    (SlotErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one edge and settle just after it, where outputs are sampled and
  // the next inputs are driven.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    EnqValid   = 1'b0;
    EnqSlot    = '0;
    EnqSrc1    = '0;
    EnqSrc2    = '0;
    EnqSrc1Rdy = 1'b0;
    EnqSrc2Rdy = 1'b0;
    EnqData    = '0;
    WakeValid  = 1'b0;
    WakeTag    = '0;
    Flush      = 1'b0;
    IssueReady = 1'b0;
  endtask

  task automatic enq(input logic [4:0] s, input logic [31:0] d,
                     input logic [5:0] t1, input logic r1,
                     input logic [5:0] t2, input logic r2);
    EnqValid   = 1'b1;
    EnqSlot    = s;
    EnqData    = d;
    EnqSrc1    = t1;
    EnqSrc1Rdy = r1;
    EnqSrc2    = t2;
    EnqSrc2Rdy = r2;
  endtask

  task automatic do_reset();
    idle_inputs();
    Rest = 1'b1;
    tick();
    tick();
    Rest = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nCompared++;
    if ({IssueValid, FreeWable, Occupancy, SlotErr} !== 7'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_state: got v=%0b fw=%0b occ=%0d err=%0b, want all 0",
               IssueValid, FreeWable, Occupancy, SlotErr);
    end
    // Put an op into the held issue register, then reset over it.
    enq(5'd8, 32'hA5A5_0001, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    EnqValid = 1'b0;
    tick();
    nCompared++;
    if ({IssueValid, IssueSlot} !== {1'b1, 5'd8}) begin
      nMismatched++;
      $display("[TB] FAIL reset_preload: got v=%0b slot=%0d, want v=1 slot=8", IssueValid, IssueSlot);
    end
    Rest = 1'b1;
    enq(5'd4, 32'hDEAD_0004, 6'd0, 1'b1, 6'd0, 1'b1);
    Flush = 1'b1; IssueReady = 1'b1; WakeValid = 1'b1;
    tick();
    nCompared++;
    if ({IssueValid, IssueData, IssueSlot, FreeWable, FreeDin, Occupancy, SlotErr} !== 45'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_override: got v=%0b d=%0h s=%0d fw=%0b fd=%0d occ=%0d err=%0b, want all 0",
               IssueValid, IssueData, IssueSlot, FreeWable, FreeDin, Occupancy, SlotErr);
    end
    Rest = 1'b0;
    idle_inputs();
    IssueReady = 1'b1;
    tick();
    nCompared++;
    if ({IssueValid, FreeWable, Occupancy} !== 6'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_no_return: got v=%0b fw=%0b occ=%0d, want 0 0 0", IssueValid, FreeWable, Occupancy);
    end
  endtask

  task automatic test_single();
    do_reset();
    IssueReady = 1'b1;
    enq(5'd8, 32'h1234_5678, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    nCompared++;
    if ({IssueValid, Occupancy} !== {1'b0, 4'd1}) begin
      nMismatched++;
      $display("[TB] FAIL single_enq: got v=%0b occ=%0d, want v=0 occ=1", IssueValid, Occupancy);
    end
    EnqValid = 1'b0;
    tick();
    nCompared++;
    if ({IssueValid, IssueSlot, IssueData, FreeWable, FreeDin, Occupancy} !== {1'b1, 5'd8, 32'h1234_5678, 1'b1, 5'd8, 4'd0}) begin
      nMismatched++;
      $display("[TB] FAIL single_issue: got v=%0b s=%0d d=%0h fw=%0b fd=%0d occ=%0d, want 1 8 12345678 1 8 0",
               IssueValid, IssueSlot, IssueData, FreeWable, FreeDin, Occupancy);
    end
    tick();
    nCompared++;
    if ({IssueValid, FreeWable} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL single_drain: got v=%0b fw=%0b, want 0 0", IssueValid, FreeWable);
    end
  endtask

  task automatic test_order();
    logic [4:0] slots [3];
    slots[0] = 5'd4; slots[1] = 5'd12; slots[2] = 5'd0;
    do_reset();
    IssueReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) enq(slots[k], 32'hB000_0000 | 32'(slots[k]), 6'd0, 1'b1, 6'd0, 1'b1);
      else EnqValid = 1'b0;
      tick();
      if (k > 0) begin
        nCompared++;
        if ({IssueValid, IssueSlot, FreeWable, FreeDin} !== {1'b1, slots[k-1], 1'b1, slots[k-1]}) begin
          nMismatched++;
          $display("[TB] FAIL order_%0d: got v=%0b s=%0d fw=%0b fd=%0d, want slot %0d", k,
                   IssueValid, IssueSlot, FreeWable, FreeDin, slots[k-1]);
        end
      end
    end
    tick();
    nCompared++;
    if ({IssueValid, Occupancy} !== 5'd0) begin
      nMismatched++;
      $display("[TB] FAIL order_end: got v=%0b occ=%0d, want 0 0", IssueValid, Occupancy);
    end
  endtask

  task automatic test_age();
    logic [4:0] slots [4];
    slots[0] = 5'd12; slots[1] = 5'd4; slots[2] = 5'd28; slots[3] = 5'd0;
    do_reset();
    IssueReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      enq(slots[k], 32'hA000_0000 | 32'(slots[k]), 6'd7, 1'b0, 6'd3, 1'b1);
      tick();
    end
    EnqValid = 1'b0;
    WakeValid = 1'b1; WakeTag = 6'd7;
    tick();
    nCompared++;
    if ({IssueValid, Occupancy} !== {1'b0, 4'd4}) begin
      nMismatched++;
      $display("[TB] FAIL age_wake_edge: got v=%0b occ=%0d, want v=0 occ=4", IssueValid, Occupancy);
    end
    WakeValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      nCompared++;
      if ({IssueValid, IssueSlot, IssueData} !== {1'b1, slots[k], 32'hA000_0000 | 32'(slots[k])}) begin
        nMismatched++;
        $display("[TB] FAIL age_%0d: got v=%0b s=%0d d=%0h, want slot %0d", k, IssueValid, IssueSlot, IssueData, slots[k]);
      end
    end
  endtask

  task automatic test_wakeup();
    do_reset();
    IssueReady = 1'b1;
    enq(5'd16, 32'hC0DE_0016, 6'd9, 1'b0, 6'd2, 1'b1);
    tick();
    EnqValid = 1'b0;
    WakeValid = 1'b1; WakeTag = 6'd10;
    tick();
    nCompared++;
    if ({IssueValid, Occupancy} !== {1'b0, 4'd1}) begin
      nMismatched++;
      $display("[TB] FAIL wake_wrong_tag: got v=%0b occ=%0d, want v=0 occ=1", IssueValid, Occupancy);
    end
    WakeTag = 6'd9;
    tick();
    nCompared++;
    if (IssueValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL wake_edge: got v=%0b, want 0", IssueValid);
    end
    WakeValid = 1'b0;
    tick();
    nCompared++;
    if ({IssueValid, IssueSlot, IssueData, FreeDin} !== {1'b1, 5'd16, 32'hC0DE_0016, 5'd16}) begin
      nMismatched++;
      $display("[TB] FAIL wake_issue: got v=%0b s=%0d d=%0h fd=%0d, want 1 16 c0de0016 16",
               IssueValid, IssueSlot, IssueData, FreeDin);
    end
    enq(5'd20, 32'hC0DE_0020, 6'd11, 1'b0, 6'd11, 1'b0);
    WakeValid = 1'b1; WakeTag = 6'd11;
    tick();
    nCompared++;
    if ({IssueValid, Occupancy} !== {1'b0, 4'd1}) begin
      nMismatched++;
      $display("[TB] FAIL wake_same_cycle_enq: got v=%0b occ=%0d, want v=0 occ=1", IssueValid, Occupancy);
    end
    EnqValid = 1'b0; WakeValid = 1'b0;
    tick();
    nCompared++;
    if ({IssueValid, IssueSlot} !== {1'b1, 5'd20}) begin
      nMismatched++;
      $display("[TB] FAIL wake_same_cycle_issue: got v=%0b s=%0d, want 1 20", IssueValid, IssueSlot);
    end
  endtask

  task automatic test_hold();
    do_reset();
    enq(5'd4, 32'h0000_AAAA, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    enq(5'd8, 32'h0000_BBBB, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    nCompared++;
    if ({IssueValid, IssueSlot, FreeWable, FreeDin, Occupancy} !== {1'b1, 5'd4, 1'b1, 5'd4, 4'd1}) begin
      nMismatched++;
      $display("[TB] FAIL hold_first: got v=%0b s=%0d fw=%0b fd=%0d occ=%0d, want 1 4 1 4 1",
               IssueValid, IssueSlot, FreeWable, FreeDin, Occupancy);
    end
    EnqValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      nCompared++;
      if ({IssueValid, IssueSlot, IssueData, FreeWable, Occupancy} !== {1'b1, 5'd4, 32'h0000_AAAA, 1'b0, 4'd1}) begin
        nMismatched++;
        $display("[TB] FAIL hold_%0d: got v=%0b s=%0d d=%0h fw=%0b occ=%0d, want 1 4 aaaa 0 1", k,
                 IssueValid, IssueSlot, IssueData, FreeWable, Occupancy);
      end
    end
    IssueReady = 1'b1;
    tick();
    nCompared++;
    if ({IssueValid, IssueSlot, IssueData, FreeWable, FreeDin, Occupancy} !== {1'b1, 5'd8, 32'h0000_BBBB, 1'b1, 5'd8, 4'd0}) begin
      nMismatched++;
      $display("[TB] FAIL hold_release: got v=%0b s=%0d d=%0h fw=%0b fd=%0d occ=%0d, want 1 8 bbbb 1 8 0",
               IssueValid, IssueSlot, IssueData, FreeWable, FreeDin, Occupancy);
    end
    tick();
    nCompared++;
    if ({IssueValid, FreeWable} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL hold_drain: got v=%0b fw=%0b, want 0 0", IssueValid, FreeWable);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      enq(5'(k * 4), 32'hF000_0000 | 32'(k), 6'd5, 1'b0, 6'd1, 1'b1);
      tick();
    end
    EnqValid = 1'b0;
    WakeValid = 1'b1; WakeTag = 6'd5;
    tick();
    nCompared++;
    if ({IssueValid, Occupancy} !== {1'b0, 4'd8}) begin
      nMismatched++;
      $display("[TB] FAIL flush_full: got v=%0b occ=%0d, want v=0 occ=8", IssueValid, Occupancy);
    end
    WakeValid = 1'b0;
    tick();
    nCompared++;
    if ({IssueValid, IssueSlot, FreeWable, Occupancy} !== {1'b1, 5'd0, 1'b1, 4'd7}) begin
      nMismatched++;
      $display("[TB] FAIL flush_load: got v=%0b s=%0d fw=%0b occ=%0d, want 1 0 1 7", IssueValid, IssueSlot, FreeWable, Occupancy);
    end
    Flush = 1'b1;
    enq(5'd0, 32'hF000_00FF, 6'd0, 1'b1, 6'd0, 1'b1);
    WakeValid = 1'b1;
    tick();
    nCompared++;
    if ({IssueValid, FreeWable, Occupancy} !== 6'd0) begin
      nMismatched++;
      $display("[TB] FAIL flush_hold: got v=%0b fw=%0b occ=%0d, want 0 0 0", IssueValid, FreeWable, Occupancy);
    end
    idle_inputs();
    IssueReady = 1'b1;
    tick();
    nCompared++;
    if ({IssueValid, FreeWable, Occupancy} !== 6'd0) begin
      nMismatched++;
      $display("[TB] FAIL flush_enq_dropped: got v=%0b fw=%0b occ=%0d, want 0 0 0", IssueValid, FreeWable, Occupancy);
    end
    enq(5'd24, 32'hF000_0024, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    EnqValid = 1'b0;
    Flush = 1'b1;
    tick();
    nCompared++;
    if ({IssueValid, FreeWable, Occupancy} !== 6'd0) begin
      nMismatched++;
      $display("[TB] FAIL flush_over_load: got v=%0b fw=%0b occ=%0d, want 0 0 0", IssueValid, FreeWable, Occupancy);
    end
    Flush = 1'b0;
  endtask

  task automatic test_slot_err();
    do_reset();
    IssueReady = 1'b1;
    enq(5'd20, 32'h0000_0111, 6'd13, 1'b0, 6'd1, 1'b1);
    tick();
    enq(5'd20, 32'h0000_0222, 6'd13, 1'b0, 6'd1, 1'b1);
    tick();
    nCompared++;
    if ({SlotErr, Occupancy} !== {CheckEn, 4'd1}) begin
      nMismatched++;
      $display("[TB] FAIL dup_enq: got err=%0b occ=%0d, want err=%0b occ=1", SlotErr, Occupancy, CheckEn);
    end
    EnqValid = 1'b0;
    WakeValid = 1'b1; WakeTag = 6'd13;
    tick();
    WakeValid = 1'b0;
    tick();
    nCompared++;
    if ({IssueValid, IssueSlot, IssueData} !== {1'b1, 5'd20, (CheckEn ? 32'h0000_0111 : 32'h0000_0222)}) begin
      nMismatched++;
      $display("[TB] FAIL dup_payload: got v=%0b s=%0d d=%0h, want 1 20 %0h", IssueValid, IssueSlot, IssueData,
               (CheckEn ? 32'h0000_0111 : 32'h0000_0222));
    end
    enq(5'd22, 32'h0000_0333, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    nCompared++;
    if ({SlotErr, Occupancy} !== {CheckEn, (CheckEn ? 4'd0 : 4'd1)}) begin
      nMismatched++;
      $display("[TB] FAIL misaligned_enq: got err=%0b occ=%0d, want err=%0b", SlotErr, Occupancy, CheckEn);
    end
    EnqValid = 1'b0;
    tick();
    nCompared++;
    if ({IssueValid, (IssueValid ? IssueSlot : 5'd0)} !== {!CheckEn, (CheckEn ? 5'd0 : 5'd22)}) begin
      nMismatched++;
      $display("[TB] FAIL misaligned_issue: got v=%0b s=%0d, want v=%0b", IssueValid, IssueSlot, !CheckEn);
    end
    do_reset();
    nCompared++;
    if (SlotErr !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL slot_err_reset: got %0b, want 0", SlotErr);
    end
  endtask

  // Random traffic against a queue kept in enqueue order: the oldest ready
  // element is the one that issues.
  task automatic test_random();
    ent_t        mq [$];
    ent_t        e;
    logic [4:0]  freeList [$];
    bit          mIssV;
    logic [31:0] mIssD;
    logic [4:0]  mIssS;
    bit          mFreeW;
    logic [4:0]  mFreeD;
    bit          used;
    int          pick;
    int          oldest;
    do_reset();
    mIssV = 0; mIssD = '0; mIssS = '0; mFreeW = 0; mFreeD = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_inputs();
      IssueReady = ($urandom_range(0, 9) < 7);
      WakeValid  = ($urandom_range(0, 9) < 4);
      WakeTag    = 6'($urandom_range(0, 15));
      Flush      = ($urandom_range(0, 79) == 0);
      Rest       = ($urandom_range(0, 299) == 0);
      freeList.delete();
      for (int s = 0; s < 8; s++) begin
        used = 0;
        foreach (mq[q]) if (mq[q].slot == 5'(s * 4)) used = 1;
        if (!used) freeList.push_back(5'(s * 4));
      end
      if (freeList.size() > 0 && $urandom_range(0, 9) < 5) begin
        pick = $urandom_range(0, freeList.size() - 1);
        enq(freeList[pick], $urandom, 6'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
            6'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
      end

      if (Rest) begin
        mq.delete();
        mIssV = 0; mIssD = '0; mIssS = '0; mFreeW = 0; mFreeD = '0;
      end else if (Flush) begin
        mq.delete();
        mIssV = 0; mFreeW = 0;
      end else begin
        oldest = -1;
        for (int q = 0; q < mq.size(); q++) begin
          if (oldest < 0 && mq[q].r1 && mq[q].r2) oldest = q;
        end
        mFreeW = 0;
        if ((!mIssV || IssueReady) && oldest >= 0) begin
          mIssV = 1; mIssD = mq[oldest].data; mIssS = mq[oldest].slot;
          mFreeW = 1; mFreeD = mq[oldest].slot;
          mq.delete(oldest);
        end else if (IssueReady) begin
          mIssV = 0;
        end
        if (WakeValid) begin
          foreach (mq[q]) begin
            if (mq[q].t1 == WakeTag) mq[q].r1 = 1;
            if (mq[q].t2 == WakeTag) mq[q].r2 = 1;
          end
        end
        if (EnqValid) begin
          e.slot = EnqSlot; e.data = EnqData; e.t1 = EnqSrc1; e.t2 = EnqSrc2;
          e.r1 = EnqSrc1Rdy || (WakeValid && EnqSrc1 == WakeTag);
          e.r2 = EnqSrc2Rdy || (WakeValid && EnqSrc2 == WakeTag);
          mq.push_back(e);
        end
      end

      tick();

      nCompared++;
      if (IssueValid !== mIssV) begin
        nMismatched++;
        $display("[TB] FAIL rnd_valid @%0d: got %0b, want %0b", cyc, IssueValid, mIssV);
      end
      if (mIssV) begin
        nCompared++;
        if ({IssueSlot, IssueData} !== {mIssS, mIssD}) begin
          nMismatched++;
          $display("[TB] FAIL rnd_payload @%0d: got s=%0d d=%0h, want s=%0d d=%0h", cyc, IssueSlot, IssueData, mIssS, mIssD);
        end
      end
      nCompared++;
      if (FreeWable !== mFreeW) begin
        nMismatched++;
        $display("[TB] FAIL rnd_free @%0d: got %0b, want %0b", cyc, FreeWable, mFreeW);
      end
      if (mFreeW) begin
        nCompared++;
        if (FreeDin !== mFreeD) begin
          nMismatched++;
          $display("[TB] FAIL rnd_freedin @%0d: got %0d, want %0d", cyc, FreeDin, mFreeD);
        end
      end
      nCompared++;
      if (Occupancy !== 4'(mq.size())) begin
        nMismatched++;
        $display("[TB] FAIL rnd_occ @%0d: got %0d, want %0d", cyc, Occupancy, mq.size());
      end
      nCompared++;
      if (SlotErr !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL rnd_sloterr @%0d: got %0b, want 0", cyc, SlotErr);
      end
    end
    Rest = 1'b0;
    idle_inputs();
  endtask

  initial begin
    Rest = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_order();
    test_age();
    test_wakeup();
    test_hold();
    test_flush();
    test_slot_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
